idu_buf: RTL and testbench

IDU_BUF -- requirements
Module: idu_buf

---
 rtl/idu_buf_if.sv | 35 +++
 rtl/idu_buf.sv | 216 +++++++++++++++++++++
 tb/tb_idu_buf.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/idu_buf_if.sv
// rtl/idu_buf_if.sv - fetch-to-decode stream and decoded-bundle signal group
interface idu_buf_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [2:0]      alu_funct3;
    logic [6:0]      funct7;
    logic [9:0]      ctrl;
    logic [1:0]      mem_size;
    logic            mem_unsigned;

    modport master (
        output flush, in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, out_pc, imm, rd, rs1, rs2,
               funct3, alu_funct3, funct7, ctrl, mem_size, mem_unsigned
    );

    modport slave (
        input  flush, in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, out_pc, imm, rd, rs1, rs2,
               funct3, alu_funct3, funct7, ctrl, mem_size, mem_unsigned
    );
endinterface

// File: rtl/idu_buf.sv
// rtl/idu_buf.sv - instruction queue with registered RISC-V decode stage
module idu_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    idu_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    assign bus.in_ready = (count < (AW+1)'(DEPTH));
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count != '0) && (!bus.out_valid || bus.out_ready);

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [31:0] ins;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins   = q_instr[rd_ptr];
    assign opc   = ins[6:2];
    assign f3    = ins[14:12];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rd, d_rs1, d_rs2;
    logic [2:0]      d_alu;
    logic [6:0]      d_f7;
    logic [1:0]      d_size;
    logic            d_uns;
    logic word_op, mm_re, mm_we, pass, branch, jump, op2_imm, op1_pc, rd_we, ill;

    always_comb begin
        d_imm = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_alu = '0; d_f7 = '0;
        d_size = '0; d_uns = 1'b0;
        word_op = 1'b0; mm_re = 1'b0; mm_we = 1'b0; pass = 1'b0; branch = 1'b0;
        jump = 1'b0; op2_imm = 1'b0; op1_pc = 1'b0; rd_we = 1'b0; ill = 1'b0;
        case (opc)
            OPC_LOAD: begin
                mm_re = 1'b1; rd_we = 1'b1; op2_imm = 1'b1;
                d_imm = sext(imm_i); d_rd = ins[11:7]; d_rs1 = ins[19:15];
                d_size = f3[1:0]; d_uns = f3[2];
                // LD and LWU only exist on RV64
                if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)))
                    ill = 1'b1;
            end
            OPC_STORE: begin
                mm_we = 1'b1; op2_imm = 1'b1;
                d_imm = sext(imm_s); d_rs1 = ins[19:15]; d_rs2 = ins[24:20];
                d_size = f3[1:0];
                if (f3[2] || (XLEN == 32 && f3 == 3'b011)) ill = 1'b1;
            end
            OPC_BRANCH: begin
                branch = 1'b1; op1_pc = 1'b1; op2_imm = 1'b1;
                d_imm = sext(imm_b); d_rs1 = ins[19:15]; d_rs2 = ins[24:20];
            end
            OPC_JAL: begin
                jump = 1'b1; rd_we = 1'b1; op1_pc = 1'b1; op2_imm = 1'b1; pass = 1'b1;
                d_imm = sext(imm_j); d_rd = ins[11:7];
            end
            OPC_JALR: begin
                jump = 1'b1; rd_we = 1'b1; op2_imm = 1'b1; pass = 1'b1;
                d_imm = sext(imm_i); d_rd = ins[11:7]; d_rs1 = ins[19:15];
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                rd_we = 1'b1; op2_imm = 1'b1; pass = 1'b1;
                d_rd = ins[11:7]; d_rs1 = ins[19:15]; d_alu = f3;
                if (opc == OPC_OP_IMM32) begin
                    word_op = 1'b1;
                    if (XLEN == 32) ill = 1'b1;
                end
                if (f3[1:0] == 2'b01) begin
                    // shifts: RV64 widens shamt into instr[25], so funct7 bit 0 is not part of the op
                    if (XLEN == 64) begin
                        d_imm = XLEN'(ins[25:20]);
                        d_f7  = {ins[31:26], 1'b0};
                    end else begin
                        d_imm = XLEN'(ins[24:20]);
                        d_f7  = ins[31:25];
                    end
                end else begin
                    d_imm = sext(imm_i);
                end
            end
            OPC_AUIPC: begin
                rd_we = 1'b1; op1_pc = 1'b1; op2_imm = 1'b1; pass = 1'b1;
                d_imm = sext(imm_u); d_rd = ins[11:7];
            end
            OPC_LUI: begin
                rd_we = 1'b1; op2_imm = 1'b1; pass = 1'b1;
                d_imm = sext(imm_u); d_rd = ins[11:7];
            end
            OPC_OP, OPC_OP32: begin
                rd_we = 1'b1; pass = 1'b1;
                d_rd = ins[11:7]; d_rs1 = ins[19:15]; d_rs2 = ins[24:20];
                d_alu = f3; d_f7 = ins[31:25];
                if (opc == OPC_OP32) begin
                    word_op = 1'b1;
                    if (XLEN == 32) ill = 1'b1;
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                d_imm = sext(imm_i); d_rd = ins[11:7]; d_rs1 = ins[19:15];
            end
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) ill = 1'b1;
        // an illegal bundle carries only pc, funct3 and imm through to the trap path
        if (ill) begin
            word_op = 1'b0; mm_re = 1'b0; mm_we = 1'b0; pass = 1'b0; branch = 1'b0;
            jump = 1'b0; op2_imm = 1'b0; op1_pc = 1'b0; rd_we = 1'b0;
            d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_f7 = '0; d_alu = '0;
            d_size = '0; d_uns = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_or_rst()) begin
            q_instr[wr_ptr] <= bus.instr_in;
            q_pc[wr_ptr]    <= bus.pc_in;
        end
    end

    function automatic logic flush_or_rst();
        return rst || bus.flush;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_imm;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic [2:0]      r_f3, r_alu;
    logic [6:0]      r_f7;
    logic [9:0]      r_ctrl;
    logic [1:0]      r_size;
    logic            r_uns;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0; r_pc <= '0; r_imm <= '0; r_rd <= '0; r_rs1 <= '0;
            r_rs2 <= '0; r_f3 <= '0; r_alu <= '0; r_f7 <= '0; r_ctrl <= '0;
            r_size <= '0; r_uns <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (pop) begin
            r_valid <= 1'b1;
            r_pc    <= q_pc[rd_ptr];
            r_imm   <= d_imm;
            r_rd    <= d_rd;
            r_rs1   <= d_rs1;
            r_rs2   <= d_rs2;
            r_f3    <= f3;
            r_alu   <= d_alu;
            r_f7    <= d_f7;
            r_ctrl  <= {word_op, mm_re, mm_we, pass, branch, jump, op2_imm, op1_pc, rd_we, ill};
            r_size  <= d_size;
            r_uns   <= d_uns;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.imm          = r_imm;
    assign bus.rd           = r_rd;
    assign bus.rs1          = r_rs1;
    assign bus.rs2          = r_rs2;
    assign bus.funct3       = r_f3;
    assign bus.alu_funct3   = r_alu;
    assign bus.funct7       = r_f7;
    assign bus.ctrl         = r_ctrl;
    assign bus.mem_size     = r_size;
    assign bus.mem_unsigned = r_uns;
endmodule

// File: tb/tb_idu_buf.sv
// tb/tb_idu_buf.sv - directed checks of idu_buf queue timing and RV32/RV64 decode
module tb_idu_buf;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    idu_buf_if #(.XLEN(32)) if32 ();
    idu_buf_if #(.XLEN(64)) if64 ();

    idu_buf #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    idu_buf #(.XLEN(64), .DEPTH(4)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push32(input logic [31:0] instr, input logic [31:0] pc);
        if32.in_valid = 1'b1; if32.instr_in = instr; if32.pc_in = pc;
        step();
        if32.in_valid = 1'b0;
    endtask

    // push at cycle N, bundle must be valid at N+2
    task automatic issue32(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        push32(instr, pc);
        step();
        check({tag, "_valid"}, if32.out_valid, 1);
        check({tag, "_pc"}, if32.out_pc, pc);
    endtask

    task automatic issue64(input string tag, input logic [31:0] instr, input logic [63:0] pc);
        if64.in_valid = 1'b1; if64.instr_in = instr; if64.pc_in = pc;
        step();
        if64.in_valid = 1'b0;
        step();
        check({tag, "_valid"}, if64.out_valid, 1);
        check({tag, "_pc"}, if64.out_pc, pc);
    endtask

    initial begin
        rst = 1'b1;
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.instr_in = '0; if32.pc_in = '0; if32.out_ready = 1'b0;
        if64.flush = 1'b0; if64.in_valid = 1'b0; if64.instr_in = '0; if64.pc_in = '0; if64.out_ready = 1'b0;
        step(); step();
        check("rst_out_valid", if32.out_valid, 0);
        check("rst_in_ready", if32.in_ready, 1);
        check("rst_imm", if32.imm, 0);
        check("rst_ctrl", if32.ctrl, 0);
        rst = 1'b0;
        step();

        // addi x1,x0,-1
        if32.out_ready = 1'b1;
        push32(32'hFFF00093, 32'h100);
        check("addi_n1_valid", if32.out_valid, 0);
        step();
        check("addi_valid", if32.out_valid, 1);
        check("addi_imm", if32.imm, 32'hFFFF_FFFF);
        check("addi_rd", if32.rd, 1);
        check("addi_rs1", if32.rs1, 0);
        check("addi_ctrl", if32.ctrl, 10'h04A);
        check("addi_pc", if32.out_pc, 32'h100);
        step();
        check("addi_drained", if32.out_valid, 0);

        // lh x5,4(x6)
        issue32("lh", 32'h00431283, 32'h104);
        check("lh_size", if32.mem_size, 1);
        check("lh_uns", if32.mem_unsigned, 0);
        check("lh_ctrl", if32.ctrl, 10'h10A);
        check("lh_rd", if32.rd, 5);
        check("lh_imm", if32.imm, 4);
        check("lh_alu", if32.alu_funct3, 0);

        issue32("addw32", 32'h003100BB, 32'h108);
        check("addw32_ctrl", if32.ctrl, 10'h001);
        check("addw32_rd", if32.rd, 0);

        // beq x1,x2,-8
        issue32("beq", 32'hFE208CE3, 32'h10C);
        check("beq_imm", if32.imm, 32'hFFFF_FFF8);
        check("beq_ctrl", if32.ctrl, 10'h02C);
        check("beq_rs2", if32.rs2, 2);
        check("beq_rd", if32.rd, 0);

        // sw x2,8(x1)
        issue32("sw", 32'h0020A423, 32'h110);
        check("sw_imm", if32.imm, 8);
        check("sw_ctrl", if32.ctrl, 10'h088);
        check("sw_size", if32.mem_size, 2);

        issue32("zero_word", 32'h0000_0000, 32'h114);
        check("zero_word_ctrl", if32.ctrl, 10'h001);
        step();

        // backpressure fill: 4 queued plus 1 in the output register
        if32.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if32.in_valid = 1'b1;
            if32.instr_in = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            if32.pc_in = 32'h200 + 32'(4 * i);
            check($sformatf("fill_in_ready_%0d", i), if32.in_ready, (i < 5) ? 1 : 0);
            step();
        end
        if32.in_valid = 1'b0;
        check("fill_full", if32.in_ready, 0);
        check("hold_pc", if32.out_pc, 32'h200);
        step();
        check("hold_valid", if32.out_valid, 1);
        check("hold_pc2", if32.out_pc, 32'h200);
        check("hold_rd", if32.rd, 1);
        if32.out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("drain_valid_%0d", i), if32.out_valid, 1);
            check($sformatf("drain_pc_%0d", i), if32.out_pc, 32'h200 + 32'(4 * i));
        end
        step();
        check("drain_empty", if32.out_valid, 0);

        // flush with three queued and one in the output register
        if32.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push32(32'h00100093, 32'h400 + 32'(4 * i));
        if32.flush = 1'b1; if32.in_valid = 1'b1; if32.instr_in = 32'h00100093; if32.pc_in = 32'h4F0;
        step();
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        check("flush_valid", if32.out_valid, 0);
        check("flush_count", dut32.count, 0);
        check("flush_in_ready", if32.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("flush_quiet_%0d", i), if32.out_valid, 0);
        end
        issue32("post_flush", 32'h00700393, 32'h300);
        check("post_flush_rd", if32.rd, 7);
        step();

        // reset while stalled
        if32.out_ready = 1'b0;
        push32(32'hFFF00093, 32'h500);
        push32(32'hFFF00093, 32'h504);
        check("prerst_valid", if32.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; if32.out_ready = 1'b1;
        check("rst_mid_valid", if32.out_valid, 0);
        check("rst_mid_imm", if32.imm, 0);
        check("rst_mid_ctrl", if32.ctrl, 0);
        check("rst_mid_pc", if32.out_pc, 0);
        check("rst_mid_rd", if32.rd, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_quiet_%0d", i), if32.out_valid, 0);
        end

        // RV64 decode
        if64.out_ready = 1'b1;
        issue64("slli64", 32'h02811113, 64'h1000);
        check("slli64_imm", if64.imm, 40);
        check("slli64_f7", if64.funct7, 0);
        check("slli64_rd", if64.rd, 2);
        issue64("lui64", 32'h800001B7, 64'h1004);
        check("lui64_imm", if64.imm, 64'hFFFF_FFFF_8000_0000);
        check("lui64_ctrl", if64.ctrl, 10'h04A);
        issue64("addw64", 32'h003100BB, 64'h1008);
        check("addw64_ctrl", if64.ctrl, 10'h242);
        check("addw64_rs2", if64.rs2, 3);
        // ld x5,4(x6)
        issue64("ld64", 32'h00433283, 64'h100C);
        check("ld64_size", if64.mem_size, 3);
        check("ld64_ctrl", if64.ctrl, 10'h10A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
